// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and constants for the operand forwarding controller
package fwd_pkg;

  // Slot rd field is sized for the widest supported register address; narrower ones zero-extend.
  localparam int SLOT_AW = 8;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_IMM = 2'd3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fwd_state_e;

  typedef struct packed {
    logic               valid;
    logic               wr_en;
    logic [SLOT_AW-1:0] rd;
    logic               is_load;
  } slot_t;

endpackage

// File: rtl/fwd_slot_pipe.sv
// rtl/fwd_slot_pipe.sv - two-deep record of the last issued instructions (EX, MEM)
module fwd_slot_pipe
  import fwd_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  flush_i,
  input  logic  issue_i,
  input  slot_t id_slot_i,
  output slot_t slot1_o,
  output slot_t slot2_o
);

  slot_t slot1_q, slot1_d;
  slot_t slot2_q, slot2_d;

  always_comb begin
    slot1_d = '0;
    slot2_d = '0;
    if (!flush_i) begin
      slot2_d = slot1_q;
      slot1_d = issue_i ? id_slot_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot1_q <= '0;
      slot2_q <= '0;
    end else begin
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
    end
  end

  assign slot1_o = slot1_q;
  assign slot2_o = slot2_q;

endmodule

// File: rtl/fwd_sel_ctrl.sv
// rtl/fwd_sel_ctrl.sv - operand mux select, load-use stall and stall counter
module fwd_sel_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_use_imm,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        s,
  output logic              stall,
  output logic              issue,
  output logic [CNT_W-1:0]  stall_cnt
);

  slot_t              id_slot, slot1, slot2;
  logic [SLOT_AW-1:0] rs_x;
  logic               rs_nz, match1, match2, hazard;
  fwd_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               unused_slot2_load;

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = id_valid;
    id_slot.wr_en   = id_wr_en;
    id_slot.rd      = SLOT_AW'(id_rd);
    id_slot.is_load = id_is_load;
  end

  fwd_slot_pipe u_slots (
    .clk_i     (c),
    .rst_ni    (rst_n),
    .flush_i   (flush),
    .issue_i   (issue),
    .id_slot_i (id_slot),
    .slot1_o   (slot1),
    .slot2_o   (slot2)
  );

  assign unused_slot2_load = slot2.is_load;

  assign rs_x   = SLOT_AW'(id_rs);
  assign rs_nz  = (id_rs != '0);
  assign match1 = slot1.valid & slot1.wr_en & (slot1.rd == rs_x) & rs_nz;
  assign match2 = slot2.valid & slot2.wr_en & (slot2.rd == rs_x) & rs_nz;

  always_comb begin
    s = SEL_RF;
    if (!id_valid)      s = SEL_RF;
    else if (id_use_imm) s = SEL_IMM;
    else if (!rs_nz)    s = SEL_RF;
    else if (match1)    s = SEL_EX;
    else if (match2)    s = SEL_MEM;
  end

  // In STALL slot1 is always a bubble, so the state gate is redundant but keeps the intent explicit.
  assign hazard = id_valid & ~id_use_imm & match1 & slot1.is_load;
  assign stall  = hazard & ~flush & (state_q == ST_RUN);
  assign issue  = id_valid & ~stall & ~flush;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (stall) state_d = ST_STALL;
        ST_STALL: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb/tb_fwd_sel_ctrl.sv - directed and random checks of fwd_sel_ctrl against an issue-history model
module tb_fwd_sel_ctrl;

  localparam int CNT_MAX = 15;

  logic       c, rst_n;
  logic       id_valid, id_use_imm, id_wr_en, id_is_load, flush;
  logic [4:0] id_rs, id_rd;
  logic [1:0] s;
  logic       stall, issue;
  logic [3:0] stall_cnt;

  fwd_sel_ctrl #(.REG_AW(5), .CNT_W(4)) dut (
    .c          (c),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_use_imm (id_use_imm),
    .id_wr_en   (id_wr_en),
    .id_rd      (id_rd),
    .id_is_load (id_is_load),
    .flush      (flush),
    .s          (s),
    .stall      (stall),
    .issue      (issue),
    .stall_cnt  (stall_cnt)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  typedef struct {
    int cyc;
    bit wr;
    int rd;
    bit ld;
  } ent_t;

  ent_t hist[$];
  int   cur, m_cnt;
  int   checks, failures;
  bit   p_issue, p_stall, p_fl, p_wr, p_ld;
  int   p_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs come from the list of instructions issued one and two cycles ago.
  task automatic drive(input bit v, input int rs, input bit imm, input bit wr, input int rd,
                       input bit ld, input bit fl);
    bit m1, m2, l1, est, eis;
    int es;
    id_valid = v; id_rs = rs[4:0]; id_use_imm = imm; id_wr_en = wr;
    id_rd = rd[4:0]; id_is_load = ld; flush = fl;
    #1;
    m1 = 0; m2 = 0; l1 = 0;
    foreach (hist[i]) begin
      if (hist[i].wr && hist[i].rd == rs && rs != 0) begin
        if (hist[i].cyc == cur - 1) begin m1 = 1; l1 = hist[i].ld; end
        if (hist[i].cyc == cur - 2) m2 = 1;
      end
    end
    if (!v) es = 0;
    else if (imm) es = 3;
    else if (rs == 0) es = 0;
    else if (m1) es = 1;
    else if (m2) es = 2;
    else es = 0;
    est = v & !imm & m1 & l1 & !fl;
    eis = v & !est & !fl;
    chk("sel", s, es);
    chk("stall", stall, est);
    chk("issue", issue, eis);
    chk("stall_cnt", stall_cnt, m_cnt);
    p_issue = eis; p_stall = est; p_fl = fl; p_wr = wr; p_rd = rd; p_ld = ld;
  endtask

  task automatic tick();
    ent_t e;
    @(posedge c);
    if (p_fl) hist.delete();
    else if (p_issue) begin
      e.cyc = cur; e.wr = p_wr; e.rd = p_rd; e.ld = p_ld;
      hist.push_back(e);
    end
    if (p_stall && m_cnt < CNT_MAX) m_cnt++;
    cur++;
    while (hist.size() > 0 && hist[0].cyc < cur - 2) void'(hist.pop_front());
    @(negedge c);
  endtask

  initial begin
    int c0;
    checks = 0; failures = 0; cur = 0; m_cnt = 0;
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_use_imm = 0; id_wr_en = 0; id_rd = 0; id_is_load = 0; flush = 0;
    repeat (2) @(negedge c);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_s", s, 0); chk("rst_stall", stall, 0); chk("rst_issue", issue, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    tick();

    drive(1, 0, 0, 1, 5, 0, 0); tick();
    drive(1, 5, 0, 0, 0, 0, 0); chk("ex_fwd", s, 1); chk("ex_fwd_nostall", stall, 0); tick();
    drive(1, 0, 0, 1, 5, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 5, 0, 0, 0, 0, 0); chk("mem_fwd", s, 2); tick();
    drive(1, 0, 0, 1, 5, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 5, 0, 0, 0, 0, 0); chk("rf_old", s, 0); tick();

    drive(1, 0, 0, 1, 7, 0, 0); tick();
    drive(1, 0, 0, 1, 7, 0, 0); tick();
    drive(1, 7, 0, 0, 0, 0, 0); chk("youngest", s, 1); tick();
    drive(1, 0, 0, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0); chk("r0", s, 0); tick();
    drive(1, 0, 0, 1, 9, 0, 0); tick();
    drive(1, 9, 1, 0, 0, 0, 0); chk("imm", s, 3); tick();

    drive(1, 0, 0, 1, 3, 1, 0); tick();
    c0 = m_cnt;
    drive(1, 3, 0, 0, 0, 0, 0); chk("lu_stall", stall, 1); chk("lu_issue", issue, 0); tick();
    drive(1, 3, 0, 0, 0, 0, 0); chk("lu_resume", stall, 0); chk("lu_mem", s, 2);
    chk("lu_issue2", issue, 1); chk("lu_cnt", stall_cnt, c0 + 1); tick();

    drive(1, 0, 0, 1, 3, 1, 0); tick();
    c0 = m_cnt;
    drive(1, 3, 0, 0, 0, 0, 1); chk("fl_stall", stall, 0); chk("fl_issue", issue, 0); tick();
    drive(1, 3, 0, 0, 0, 0, 0); chk("fl_rf", s, 0); chk("fl_cnt", stall_cnt, c0); tick();

    drive(1, 0, 0, 1, 3, 1, 0); tick();
    drive(1, 3, 0, 0, 0, 0, 0); chk("ar_pre", stall, 1);
    #1 rst_n = 1'b0;
    #1;
    hist.delete(); m_cnt = 0;
    chk("ar_stall", stall, 0); chk("ar_s", s, 0); chk("ar_cnt", stall_cnt, 0);
    id_valid = 0;
    #1 chk("ar_issue", issue, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0); tick();

    repeat (400) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 6) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0);
      tick();
    end

    repeat (20) begin
      drive(1, 0, 0, 1, 3, 1, 0); tick();
      drive(1, 3, 0, 0, 0, 0, 0); tick();
      drive(1, 3, 0, 0, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("sat", stall_cnt, CNT_MAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Forwarding/hazard controller that drives the 2-bit select of the registered 32-bit 4:1 operand mux in the EX input path.
- Tracks destination registers of the two youngest issued instructions and picks the operand source: register file, EX result, MEM result or immediate.
- Inserts a one-cycle bubble on load-use hazards and counts stall cycles for performance monitoring.

Parameters:
- REG_AW, 5, register address width
- CNT_W, 16, stall counter width (saturating)

Ports:
- c  in  1  clock; operand mux samples on the same posedge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs  in  REG_AW  source register of the ID instruction (the mux operand)
- id_use_imm  in  1  operand is the immediate
- id_wr_en  in  1  ID instruction writes a register
- id_rd  in  REG_AW  destination register of the ID instruction
- id_is_load  in  1  ID instruction is a load
- flush  in  1  synchronous pipeline flush (branch redirect)
- s  out  2  mux select: 0 RF, 1 EX fwd, 2 MEM fwd, 3 IMM
- stall  out  1  hold PC/ID this cycle; do not issue
- issue  out  1  ID instruction advances to EX at the next posedge
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock c, reset rst_n asynchronous active-low; all state updates on posedge c.
- Reset: slot1/slot2 invalid, state RUN, stall_cnt=0. Outputs after reset with id_valid=0: s=0, stall=0, issue=0.
- Slots: slot1 = instruction issued last cycle (now in EX); slot2 = issued two cycles ago (now in MEM). Each slot holds {valid, wr_en, rd, is_load}. Every posedge: slot2<=slot1; slot1<=ID fields if issue, else bubble (valid=0).
- Match1 = slot1.valid & slot1.wr_en & slot1.rd==id_rs & id_rs!=0. Match2 is the same check on slot2.
- s is combinational, valid in the ID cycle, and captured by the mux at the edge that moves the instruction to EX. Priority:
  - id_valid=0 -> s=0
  - id_use_imm -> s=3
  - id_rs==0 -> s=0
  - match1 -> s=1 (youngest wins)
  - match2 -> s=2
  - otherwise s=0
- The register file is write-before-read, so no third slot exists.
- Hazard = id_valid & ~id_use_imm & match1 & slot1.is_load.
- stall = hazard & ~flush. issue = id_valid & ~stall & ~flush.
- FSM has two states, RUN and STALL.
  - RUN: on stall, slot1<=bubble and go to STALL.
  - STALL: slot1 is a bubble, so hazard cannot recur. Go to RUN. The held instruction now sees the load in slot2, so s=2.
- Flush: slot1 and slot2 are invalidated at the edge; state goes to RUN. In the flush cycle stall=0 and issue=0. Flush has priority over stall.
- stall_cnt increments by 1 on every cycle with stall=1 and saturates at 2^CNT_W-1. Flush does not clear it; only reset does.
- Reset asserted mid-stall: all state clears immediately (asynchronous); stall drops without waiting for a clock.

Decomposition:
- Shared package fwd_pkg holds:
  - select constants SEL_RF=2'd0, SEL_EX=2'd1, SEL_MEM=2'd2, SEL_IMM=2'd3
  - FSM state constants ST_RUN, ST_STALL
  - slot struct {valid, wr_en, rd, is_load}
- One sub-module fwd_slot_pipe: the 2-deep slot shift register with bubble insert and flush. The top level holds the compare/priority logic, FSM and counter.

Test Plan:
- Reset: rst_n=0 mid-cycle -> s=0, stall=0, issue=0, stall_cnt=0 immediately.
- EX fwd: issue ADD r5; next cycle ID rs=5 -> s=1, stall=0. Two cycles later (bubble between) -> s=2. Three or more cycles later -> s=0.
- Priority and r0:
  - slot1.rd=7 and slot2.rd=7, rs=7 -> s=1
  - rs=0 with slot1.rd=0, wr_en=1 -> s=0
  - id_use_imm=1 with a match -> s=3
- Load-use: LW r3 issued, then ID rs=3 -> stall=1, issue=0, stall_cnt 0->1. Next cycle -> stall=0, s=2, issue=1.
- Flush during hazard: same as load-use, with flush=1 in the stall cycle -> stall=0, issue=0, stall_cnt unchanged. Next cycle ID rs=3 -> s=0.
- Saturation: CNT_W=4, force 20 load-use stalls -> stall_cnt holds 15.
